// File: rtl/jesd204_enc_8b10b.sv
// ---------------------------------------------------------------------------
// jesd204_enc_8b10b
//
// Multi-lane 8b/10b encoder for a JESD204 transmit link. Each lane encodes
// four octets per clock (byte 0 first on the wire). The running disparity
// is chained combinationally through the four bytes and carried to the next
// valid word. Each lane keeps its own disparity.
//
// Ports
//   clk      in   encoder clock
//   rst      in   asynchronous active-high reset
//   en       in   input word valid; di/di_k are consumed only when en=1
//   di       in   [LANES][4][8]  octets per lane, byte 0 transmitted first
//   di_k     in   [LANES][4]     per-octet control-character flag
//   dout     out  [LANES][4][10] encoded symbols, bit0=a ... bit5=i,
//                                bit6=f ... bit9=j (bit0 transmitted first).
//                                Named dout because `do` is a reserved word.
//   do_vld   out  dout holds a newly encoded word
//   k_err    out  [LANES] the word on dout had a control flag on a code
//                 outside K28.0-7, K23.7, K27.7, K29.7, K30.7
//   rd       out  [LANES] running disparity after byte 3 (0=neg, 1=pos)
// ---------------------------------------------------------------------------
module jesd204_enc_8b10b #(
  parameter int LANES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [LANES-1:0][3:0][7:0]   di,
  input  logic [LANES-1:0][3:0]        di_k,
  output logic [LANES-1:0][3:0][9:0]   dout,
  output logic                         do_vld,
  output logic [LANES-1:0]             k_err,
  output logic [LANES-1:0]             rd
);

  typedef struct packed {
    logic [9:0] sym;   // output bit order: bit0 = a
    logic       rd;    // running disparity after this byte
    logic       kerr;  // control flag on a code outside the valid K set
  } enc_t;

  // 5b/6b codes for a negative current disparity, written abcdei (a = MSB).
  function automatic logic [5:0] tbl6(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;  5'd31: r = 6'b101011;
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  // Encode one octet. Every sub-block table entry below is the form used
  // when the disparity entering that sub-block is negative; the positive
  // form is its complement whenever the entry is unbalanced or is one of
  // the balanced two-form codes (D.07 6b, D.x.3 4b, all K28 4b codes).
  function automatic enc_t enc_byte(input logic [7:0] b, input logic k,
                                    input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       k28;
    logic       k_ok;
    logic       use_a7;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic [9:0] code;
    enc_t       r;

    x    = b[4:0];
    y    = b[7:5];
    k28  = k && (x == 5'd28);
    k_ok = k28 || (k && (y == 3'd7) &&
           (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30));

    // 6b sub-block; an invalid K falls through to the data table
    c6 = k28 ? 6'b001111 : tbl6(x);
    if (rd_in && (($countones(c6) != 3) || (x == 5'd7)))
      c6 = ~c6;
    rd6 = rd_in ^ ($countones(c6) != 3);

    // 4b sub-block, selected by the disparity left after the 6b sub-block
    if (k28) begin
      case (y)
        3'd0:    c4 = 4'b1011;
        3'd1:    c4 = 4'b0110;
        3'd2:    c4 = 4'b1010;
        3'd3:    c4 = 4'b1100;
        3'd4:    c4 = 4'b1101;
        3'd5:    c4 = 4'b0101;
        3'd6:    c4 = 4'b1001;
        default: c4 = 4'b0111;
      endcase
    end else begin
      // A7 avoids a run of five equal bits across the sub-block boundary
      use_a7 = k_ok ||
               (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
      case (y)
        3'd0:    c4 = 4'b1011;
        3'd1:    c4 = 4'b1001;
        3'd2:    c4 = 4'b0101;
        3'd3:    c4 = 4'b1100;
        3'd4:    c4 = 4'b1101;
        3'd5:    c4 = 4'b1010;
        3'd6:    c4 = 4'b0110;
        default: c4 = use_a7 ? 4'b0111 : 4'b1110;
      endcase
    end
    if (rd6 && (k28 || ($countones(c4) != 2) || (y == 3'd3)))
      c4 = ~c4;

    code   = {c6, c4};               // abcdeifghj, a = MSB
    for (int i = 0; i < 10; i++)
      r.sym[i] = code[9-i];          // a goes out first, so a -> bit0
    r.rd   = rd6 ^ ($countones(c4) != 2);
    r.kerr = k && !k_ok;
    return r;
  endfunction

  logic [LANES-1:0][3:0][9:0] nxt_do;
  logic [LANES-1:0]           nxt_rd;
  logic [LANES-1:0]           nxt_kerr;
  logic                       rd_run;
  enc_t                       res;

  // Four-byte disparity chain per lane, evaluated in a single cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    nxt_do   = '0;
    nxt_rd   = '0;
    nxt_kerr = '0;
    rd_run   = 1'b0;
    res      = '0;
    for (int l = 0; l < LANES; l++) begin
      rd_run = rd[l];
      for (int bi = 0; bi < 4; bi++) begin
        res             = enc_byte(di[l][bi], di_k[l][bi], rd_run);
        nxt_do[l][bi]   = res.sym;
        rd_run          = res.rd;
        nxt_kerr[l]     = nxt_kerr[l] | res.kerr;
      end
      nxt_rd[l] = rd_run;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      do_vld <= 1'b0;
      k_err  <= '0;
      rd     <= '0;
    end else if (en) begin
      dout   <= nxt_do;
      do_vld <= 1'b1;
      k_err  <= nxt_kerr;
      rd     <= nxt_rd;
    end else begin
      do_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jesd204_enc_8b10b.sv
// ---------------------------------------------------------------------------
// tb_jesd204_enc_8b10b
//
// Two-lane bench for jesd204_enc_8b10b. A reference model holds the full
// 8b/10b code tables for both disparities (6b indexed by the incoming
// disparity, 4b by the disparity after the 6b sub-block) and tracks the
// running disparity as an integer sum of symbol disparities. A compare
// process checks every output against the model on each falling edge;
// directed words check hand-written code words.
// ---------------------------------------------------------------------------
module tb_jesd204_enc_8b10b;

  localparam int L = 2;

  logic                     clk;
  logic                     rst;
  logic                     en;
  logic [L-1:0][3:0][7:0]   di;
  logic [L-1:0][3:0]        di_k;
  logic [L-1:0][3:0][9:0]   dout;
  logic                     do_vld;
  logic [L-1:0]             k_err;
  logic [L-1:0]             rd;

  int total = 0;
  int bad   = 0;
  logic cmp_on = 1'b0;

  jesd204_enc_8b10b #(.LANES(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .di     (di),
    .di_k   (di_k),
    .dout   (dout),
    .do_vld (do_vld),
    .k_err  (k_err),
    .rd     (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference tables (abcdei / fghj, first bit = MSB) ------
  logic [5:0] d6n [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [5:0] d6p [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  logic [3:0] d4n [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] d4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  logic [3:0] k4n [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [3:0] k4p [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  logic [7:0] k_valid [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                               8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // Written notation abcdeifghj (a first) -> DUT bit order (a = bit0).
  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  // disp is the running disparity as an integer, -1 or +1.
  function automatic void model_byte(input logic [7:0] b, input logic k,
                                     inout int disp, output logic [9:0] code,
                                     output logic bad_k);
    int x, y;
    logic k28, kx7, a7;
    logic [5:0] six;
    logic [3:0] four;
    x     = int'(b[4:0]);
    y     = int'(b[7:5]);
    k28   = k && x == 28;
    kx7   = k && y == 7 && (x == 23 || x == 27 || x == 29 || x == 30);
    bad_k = k && !(k28 || kx7);
    if (k28) six = (disp < 0) ? 6'b001111 : 6'b110000;
    else     six = (disp < 0) ? d6n[x] : d6p[x];
    disp += 2 * $countones(six) - 6;
    a7 = kx7 || (disp < 0 && (x == 17 || x == 18 || x == 20)) ||
                (disp > 0 && (x == 11 || x == 13 || x == 14));
    if (k28)                four = (disp < 0) ? k4n[y] : k4p[y];
    else if (y == 7 && a7)  four = (disp < 0) ? 4'b0111 : 4'b1000;
    else                    four = (disp < 0) ? d4n[y] : d4p[y];
    disp += 2 * $countones(four) - 4;
    code = rev10({six, four});
  endfunction

  // ---------------- cycle-level expected state ----------------------------
  logic [L-1:0][3:0][9:0] m_do   = '0;
  logic                   m_vld  = 1'b0;
  logic [L-1:0]           m_kerr = '0;
  int                     m_disp [L];

  initial for (int l = 0; l < L; l++) m_disp[l] = -1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_do   = '0;
      m_vld  = 1'b0;
      m_kerr = '0;
      for (int l = 0; l < L; l++) m_disp[l] = -1;
    end else if (en) begin
      for (int l = 0; l < L; l++) begin
        m_kerr[l] = 1'b0;
        for (int b = 0; b < 4; b++) begin
          logic [9:0] c;
          logic bk;
          model_byte(di[l][b], di_k[l][b], m_disp[l], c, bk);
          m_do[l][b] = c;
          m_kerr[l]  = m_kerr[l] | bk;
        end
      end
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  end

  function automatic logic [L-1:0] m_rd();
    logic [L-1:0] r;
    for (int l = 0; l < L; l++) r[l] = (m_disp[l] > 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_dout",  128'(dout),   128'(m_do));
      check("cyc_vld",   128'(do_vld), 128'(m_vld));
      check("cyc_kerr",  128'(k_err),  128'(m_kerr));
      check("cyc_rd",    128'(rd),     128'(m_rd()));
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  function automatic logic [3:0][7:0] w4(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic send(input logic [L-1:0][3:0][7:0] d, input logic [L-1:0][3:0] k);
    di   = d;
    di_k = k;
    en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;
  localparam logic [9:0] D000N = 10'b1001110100;

  initial begin
    logic [9:0] mc;
    logic       mk;
    int         md;

    rst = 1'b1; en = 1'b0; di = '0; di_k = '0;

    // Pin the model with hand-derived code words.
    md = -1; model_byte(8'hBC, 1'b1, md, mc, mk);
    check("model_k285_neg", 128'(mc), 128'(rev10(K285N)));
    md = 1;  model_byte(8'hEB, 1'b0, md, mc, mk);
    check("model_d117_pos", 128'({mc, 32'(md)}), 128'({rev10(10'b1101001000), 32'(-1)}));

    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b1;
    check("rst_dout", 128'(dout),   128'(0));
    check("rst_vld",  128'(do_vld), 128'(0));
    check("rst_kerr", 128'(k_err),  128'(0));
    check("rst_rd",   128'(rd),     128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Four K28.5 from negative disparity: alternates, ends negative.
    send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'hBC, 8'hBC, 8'hBC, 8'hBC)}, 8'hFF);
    check("k285_b0", 128'(dout[0][0]), 128'(rev10(K285N)));
    check("k285_b1", 128'(dout[0][1]), 128'(rev10(K285P)));
    check("k285_b2", 128'(dout[0][2]), 128'(rev10(K285N)));
    check("k285_b3", 128'(dout[0][3]), 128'(rev10(K285P)));
    check("k285_rd_kerr_vld", 128'({rd, k_err, do_vld}), 128'(5'b00001));

    // D0.0 is a balanced symbol, so disparity stays negative on all four.
    send({w4(8'h00, 8'h00, 8'h00, 8'h00), w4(8'h00, 8'h00, 8'h00, 8'h00)}, 8'h00);
    check("d000_word", 128'(dout[0]), 128'({4{rev10(D000N)}}));
    check("d000_rd", 128'(rd[0]), 128'(0));
    send({w4(8'hB5, 8'hB5, 8'hB5, 8'hB5), w4(8'hB5, 8'hB5, 8'hB5, 8'hB5)}, 8'h00);
    check("d215_word", 128'(dout[0]), 128'({4{10'b0101010101}}));
    check("d215_rd", 128'(rd[0]), 128'(0));

    // D17.7 at negative takes A7 (+2), next D17.7 at positive takes P7 (-2).
    send({w4(8'hF1, 8'hF1, 8'h00, 8'h00), w4(8'hF1, 8'hF1, 8'h00, 8'h00)}, 8'h00);
    check("d177_neg_a7", 128'(dout[0][0]), 128'(rev10(10'b1000110111)));
    check("d177_pos_p7", 128'(dout[0][1]), 128'(rev10(10'b1000110001)));
    check("d177_rd", 128'(rd[0]), 128'(0));

    // K28.5 drives disparity positive, then D11.7 takes A7.
    send({w4(8'hBC, 8'hEB, 8'h00, 8'h00), w4(8'hBC, 8'hEB, 8'h00, 8'h00)}, 8'h11);
    check("d117_pos_a7", 128'(dout[0][1]), 128'(rev10(10'b1101001000)));
    check("d117_rd", 128'(rd[0]), 128'(0));

    // Control flag on 0x00 (invalid K) in byte 1: encoded as D0.0 at positive.
    send({w4(8'hBC, 8'h00, 8'hBC, 8'hBC), w4(8'hBC, 8'h00, 8'hBC, 8'hBC)}, 8'hFF);
    check("badk_kerr", 128'(k_err), 128'(2'b11));
    check("badk_b1", 128'(dout[0][1]), 128'(rev10(10'b0110001011)));
    check("badk_rd", 128'(rd[0]), 128'(1));
    send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'hBC, 8'hBC, 8'hBC, 8'hBC)}, 8'hFF);
    check("badk_clear", 128'(k_err), 128'(0));

    // Stall: outputs hold and disparity does not advance.
    send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'hBC, 8'hBC, 8'hBC, 8'hBC)}, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("stall_vld", 128'(do_vld), 128'(0));
      check("stall_hold", 128'({dout[0][0], dout[0][1], rd[0]}),
            128'({rev10(K285P), rev10(K285N), 1'b1}));
    end
    send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'hBC, 8'hBC, 8'hBC, 8'hBC)}, 8'hFF);
    check("stall_resume", 128'({dout[0], do_vld}),
          128'({rev10(K285N), rev10(K285P), rev10(K285N), rev10(K285P), 1'b1}));

    // Random traffic, checked by the compare process every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        for (int l = 0; l < L; l++) begin
          for (int b = 0; b < 4; b++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
              di[l][b]   = k_valid[$urandom_range(0, 11)];
              di_k[l][b] = 1'b1;
            end else begin
              di[l][b]   = 8'($urandom_range(0, 255));
              di_k[l][b] = (r == 2);
            end
          end
        end
        en = 1'b1;
      end else begin
        en = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    // Mid-stream reset: lane 0 D0.0, lane 1 K28.5.
    for (int i = 0; i < 3; i++)
      send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'h00, 8'h00, 8'h00, 8'h00)}, 8'hF0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_zero", 128'({dout, do_vld, k_err, rd}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    send({w4(8'hBC, 8'hBC, 8'hBC, 8'hBC), w4(8'h00, 8'h00, 8'h00, 8'h00)}, 8'hF0);
    check("postrst_l0", 128'(dout[0]), 128'({4{rev10(D000N)}}));
    check("postrst_l1", 128'(dout[1]),
          128'({rev10(K285P), rev10(K285N), rev10(K285P), rev10(K285N)}));
    check("postrst_rd", 128'({rd, do_vld}), 128'(3'b001));
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
